// File: rtl/sid_dsm_dac_if.sv
// Audio path between the voice mixer and the delta-sigma output stage.
interface sid_dsm_dac_if;
    logic [7:0] sample;
    logic       enable;
    logic       dout;
    logic       muted;
    logic       ramping;

    modport master (
        output sample,
        output enable,
        input  dout,
        input  muted,
        input  ramping
    );

    modport slave (
        input  sample,
        input  enable,
        output dout,
        output muted,
        output ramping
    );
endinterface

// File: rtl/sid_dsm_dac.sv
// Second-order delta-sigma audio DAC with a click-free gain ramp around midscale.
module sid_dsm_dac #(
    parameter int unsigned DIV       = 255,
    parameter int unsigned RAMP_STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    sid_dsm_dac_if.slave bus
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned GAIN_W = 9;
    localparam int unsigned ACC_W  = 14;
    localparam int unsigned SUM_W  = 16;
    localparam int unsigned PROD_W = 19;

    localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(256);
    localparam logic [GAIN_W:0]   STEP_G     = (GAIN_W + 1)'(RAMP_STEP);

    typedef enum logic [1:0] {
        MUTED,
        RAMP_UP,
        RUN,
        RAMP_DOWN
    } state_t;

    logic [CNT_W-1:0]        count;
    logic                    tick_c;
    state_t                  state;
    state_t                  state_dir_c;
    logic [GAIN_W-1:0]       gain;
    logic [GAIN_W:0]         gain_up_c;
    logic [7:0]              samp_r;
    logic                    muted_r;
    logic                    ramping_r;
    logic                    dout_r;
    logic signed [8:0]       centered_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0] u_c;
    logic signed [ACC_W-1:0] y_c;
    logic signed [ACC_W-1:0] i1;
    logic signed [ACC_W-1:0] i2;
    logic signed [SUM_W-1:0] sum1_c;
    logic signed [SUM_W-1:0] sum2_c;
    logic signed [ACC_W-1:0] i1_nx_c;
    logic signed [ACC_W-1:0] i2_nx_c;

    // Clamp an integrator sum to +/-8191 so it can never wrap.
    function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] v);
        if (v > 16'sd8191)
            return 14'sd8191;
        else if (v < -16'sd8191)
            return -14'sd8191;
        else
            return ACC_W'(v);
    endfunction

    assign tick_c = (count == CNT_W'(DIV - 1));

    // Sample/gain tick divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (tick_c)
            count <= '0;
        else
            count <= count + CNT_W'(1);
    end

    // Latch the mixed sample once per tick; midscale is silence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            samp_r <= 8'h80;
        else if (tick_c)
            samp_r <= bus.sample;
    end

    // Ramp direction follows enable every clock; a tick then steps gain that way.
    always_comb begin
        state_dir_c = state;
        case (state)
            MUTED:     if (bus.enable)  state_dir_c = RAMP_UP;
            RAMP_UP:   if (!bus.enable) state_dir_c = RAMP_DOWN;
            RUN:       if (!bus.enable) state_dir_c = RAMP_DOWN;
            RAMP_DOWN: if (bus.enable)  state_dir_c = RAMP_UP;
            default:   state_dir_c = MUTED;
        endcase
    end

    assign gain_up_c = {1'b0, gain} + STEP_G;

    // Mute FSM, gain ramp and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MUTED;
            gain      <= '0;
            muted_r   <= 1'b1;
            ramping_r <= 1'b0;
        end else begin
            muted_r   <= (state == MUTED) && (gain == '0);
            ramping_r <= (state == RAMP_UP) || (state == RAMP_DOWN);
            state     <= state_dir_c;
            if (tick_c) begin
                case (state_dir_c)
                    RAMP_UP: begin
                        if (gain_up_c >= (GAIN_W + 1)'(256)) begin
                            gain  <= GAIN_UNITY;
                            state <= RUN;
                        end else begin
                            gain <= gain_up_c[GAIN_W-1:0];
                        end
                    end
                    RAMP_DOWN: begin
                        if ({1'b0, gain} <= STEP_G) begin
                            gain  <= '0;
                            state <= MUTED;
                        end else begin
                            gain <= gain - STEP_G[GAIN_W-1:0];
                        end
                    end
                    RUN:     gain <= GAIN_UNITY;
                    default: gain <= '0;
                endcase
            end
        end
    end

    // Gain-scaled signed input; arithmetic shift floors toward -inf.
    always_comb begin
        centered_c = $signed({1'b0, samp_r}) - 9'sd128;
        prod_c     = PROD_W'(centered_c) * PROD_W'($signed({1'b0, gain}));
        u_c        = ACC_W'(prod_c >>> 8);
    end

    // Feedback level and saturating integrator updates.
    always_comb begin
        y_c     = dout_r ? 14'sd128 : -14'sd128;
        sum1_c  = SUM_W'(i1) + SUM_W'(u_c) - SUM_W'(y_c);
        sum2_c  = SUM_W'(i2) + SUM_W'(i1) - SUM_W'(y_c);
        i1_nx_c = sat(sum1_c);
        i2_nx_c = sat(sum2_c);
    end

    // Modulator state and 1-bit quantiser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1     <= '0;
            i2     <= '0;
            dout_r <= 1'b0;
        end else begin
            i1     <= i1_nx_c;
            i2     <= i2_nx_c;
            dout_r <= !i2_nx_c[ACC_W-1];
        end
    end

    assign bus.dout    = dout_r;
    assign bus.muted   = muted_r;
    assign bus.ramping = ramping_r;

endmodule
